hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core; the stall/flush side that complements EX-stage operand forwarding. It detects load-use hazards the forwarding paths cannot cover, freezes the whole pipeline while a data-memory access waits on `dmem_ready`, and flushes IF/ID on a taken branch resolved in ID. It also keeps saturating stall and flush counters and latches a sticky error on memory timeout.

## Interface
- `MEM_TIMEOUT`, default 64: number of consecutive frozen cycles without `dmem_ready` before entering ERR. Legal range is 2..2^CNT_W-1.
- `CNT_W`, default 16: width of the performance counters and the wait counter.

- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `IFID_Rs`, `IFID_Rt` in 5: source registers of the instruction in ID.
- `IFID_UsesRt` in 1: the ID instruction reads Rt as an operand. R-format, store and beq/bne set it.
- `IDEX_Rt` in 5: destination register of a load in EX.
- `IDEX_MemRead` in 1: the EX instruction is a load.
- `EXMEM_MemRead`, `EXMEM_MemWrite` in 1: the MEM-stage instruction accesses data memory.
- `dmem_ready` in 1: data memory completes the MEM-stage access this cycle.
- `ID_BranchTaken` in 1: branch or jump in ID resolved taken.
- `PCWrite` out 1: PC update enable.
- `IFID_Write` out 1: IF/ID register enable.
- `IDEX_Bubble` out 1: zero the ID/EX control fields.
- `IFID_Flush` out 1: zero the IF/ID instruction.
- `Pipe_Freeze` out 1: hold ID/EX, EX/MEM and MEM/WB, and suppress the register-file write.
- `mem_err` out 1: sticky timeout flag.
- `stall_cycles` out CNT_W: number of cycles with `PCWrite`=0 outside ERR. Saturating.
- `flush_count` out CNT_W: number of cycles with `IFID_Flush`=1. Saturating.

## Operation
- FSM states are RUN, MEM_WAIT and ERR. The wait counter `wait_cnt` is CNT_W bits wide.
- `memstall` = (`EXMEM_MemRead` | `EXMEM_MemWrite`) & !`dmem_ready`.
- `loaduse` = `IDEX_MemRead` & (`IDEX_Rt`≠0) & ((`IDEX_Rt`==`IFID_Rs`) | (`IFID_UsesRt` & `IDEX_Rt`==`IFID_Rt`)).
- Outputs are combinational from the state and inputs. They are listed in priority order; the first matching row wins:
  - ERR: `PCWrite`=0, `IFID_Write`=0, `Pipe_Freeze`=1, `IDEX_Bubble`=0, `IFID_Flush`=0.
  - `memstall` (in RUN or MEM_WAIT): same values as the ERR row.
  - `loaduse`: `PCWrite`=0, `IFID_Write`=0, `IDEX_Bubble`=1. `IFID_Flush` is suppressed; the branch re-evaluates next cycle.
  - `ID_BranchTaken`: `IFID_Flush`=1, all other signals at their defaults.
  - Default: `PCWrite`=1, `IFID_Write`=1, all other outputs 0.
- State transitions:
  - RUN → MEM_WAIT on `memstall`, with `wait_cnt`←1. Otherwise stay in RUN with `wait_cnt`←0.
  - MEM_WAIT with `dmem_ready` → RUN, `wait_cnt`←0.
  - MEM_WAIT with !`dmem_ready` and `wait_cnt`==MEM_TIMEOUT-1 → ERR, `mem_err`←1.
  - MEM_WAIT with !`dmem_ready` otherwise → stay, `wait_cnt`+1.
  - ERR is left only through reset.
- Counters increment by 1 on the qualifying cycle and hold at 2^CNT_W-1.

## Timing
- Every output has zero-cycle latency from its inputs. Only the state, `wait_cnt`, `mem_err` and the counters are registered.
- A load-use hazard stalls for exactly one cycle. On the next cycle the load is in MEM and forwarding from MEM/WB resolves the operand.
- A `dmem_ready` arriving in the first memory cycle causes no freeze.
- A wait of N cycles, with N < MEM_TIMEOUT, freezes for exactly N cycles. The freeze drops in the cycle `dmem_ready` rises.
- If `dmem_ready` never arrives: MEM_TIMEOUT frozen cycles, then ERR from the next edge.
- `memstall` concurrent with `loaduse` or a branch: freeze only. The lower-priority event is re-evaluated after the freeze ends.
- Reset, effective immediately and held while `rst`=1:
  - State RUN; `wait_cnt`, `mem_err`, `stall_cycles` and `flush_count` are 0.
  - Outputs are forced to the default row (`PCWrite`=1, `IFID_Write`=1, all others 0), independent of inputs.
  - A reset asserted in MEM_WAIT or ERR aborts to RUN.

## Structure
- Package `hazard_pkg` holds the state enum (RUN, MEM_WAIT, ERR), the default parameter constants and the register-zero constant.
- One sub-module, `sat_counter` (parameter W, ports `inc` and `count`, asynchronous reset), instantiated twice for `stall_cycles` and `flush_count`.

## Test plan
1. `IDEX_MemRead`=1, `IDEX_Rt`=8, `IFID_Rs`=8 → exactly one cycle with `PCWrite`=0, `IDEX_Bubble`=1; `stall_cycles`=1. Repeating with `IDEX_Rt`=0 gives no stall.
2. `IFID_Rt`=9=`IDEX_Rt` with `IFID_UsesRt`=0 → no stall. With `IFID_UsesRt`=1 → one-cycle stall.
3. `EXMEM_MemRead`=1 with `dmem_ready` low for 3 cycles, then high → `Pipe_Freeze`=1 for exactly 3 cycles; state returns to RUN; `stall_cycles`=3.
4. `ID_BranchTaken`=1 together with `loaduse` → cycle 1 stall with no flush; cycle 2 `IFID_Flush`=1; `flush_count`=1.
5. MEM_TIMEOUT=4 with `dmem_ready` held low → 4 frozen cycles, then ERR with `mem_err`=1 and the freeze held. Asserting `rst` mid-ERR clears everything to RUN and the defaults.
6. `stall_cycles` preset near the limit (CNT_W=4, 16 stalls) → counter holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam int MEM_TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF       = 16;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: advances on inc and holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    // count register, sticks at its maximum value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, data-memory freeze and taken-branch flush control for the
// 5-stage pipeline, with a sticky memory-timeout error and event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic [4:0]       IDEX_Rt,
    input  logic             IDEX_MemRead,
    input  logic             EXMEM_MemRead,
    input  logic             EXMEM_MemWrite,
    input  logic             dmem_ready,
    input  logic             ID_BranchTaken,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             Pipe_Freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_r, state_n_s;
    logic [CNT_W-1:0] wait_cnt_r, wait_cnt_n_s;
    logic             err_set_s;
    logic             memstall_s, loaduse_s;

    assign memstall_s = (EXMEM_MemRead | EXMEM_MemWrite) & ~dmem_ready;
    assign loaduse_s  = IDEX_MemRead & (IDEX_Rt != REG_ZERO) &
                        ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt)));

    // state, wait counter and sticky error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RUN;
            wait_cnt_r <= {CNT_W{1'b0}};
            mem_err    <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            wait_cnt_r <= wait_cnt_n_s;
            mem_err    <= mem_err | err_set_s;
        end
    end

    // next-state logic; the wait counter counts frozen cycles already spent
    always_comb begin
        state_n_s    = state_r;
        wait_cnt_n_s = wait_cnt_r;
        err_set_s    = 1'b0;
        case (state_r)
            RUN: begin
                if (memstall_s) begin
                    state_n_s    = MEM_WAIT;
                    wait_cnt_n_s = CNT_W'(1);
                end else begin
                    state_n_s    = RUN;
                    wait_cnt_n_s = {CNT_W{1'b0}};
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_n_s    = RUN;
                    wait_cnt_n_s = {CNT_W{1'b0}};
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    state_n_s = ERR;
                    err_set_s = 1'b1;
                end else begin
                    wait_cnt_n_s = wait_cnt_r + CNT_W'(1);
                end
            end
            ERR: begin
                state_n_s = ERR;
            end
            default: begin
                state_n_s    = RUN;
                wait_cnt_n_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // prioritised pipeline controls; reset forces the free-running defaults
    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        Pipe_Freeze = 1'b0;
        if (rst) begin
            PCWrite    = 1'b1;
            IFID_Write = 1'b1;
        end else if ((state_r == ERR) || memstall_s) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            Pipe_Freeze = 1'b1;
        end else if (loaduse_s) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else if (ID_BranchTaken) begin
            IFID_Flush = 1'b1;
        end else begin
            PCWrite    = 1'b1;
            IFID_Write = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~PCWrite & (state_r != ERR)),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (IFID_Flush),
        .count (flush_count)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural reference model.
module tb_hazard_ctrl;
    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    IFID_Rs = 5'd0, IFID_Rt = 5'd0, IDEX_Rt = 5'd0;
    logic          IFID_UsesRt = 1'b0, IDEX_MemRead = 1'b0;
    logic          EXMEM_MemRead = 1'b0, EXMEM_MemWrite = 1'b0;
    logic          dmem_ready = 1'b0, ID_BranchTaken = 1'b0;
    logic          PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, Pipe_Freeze, mem_err;
    logic [CW-1:0] stall_cycles, flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: error flag, frozen cycles spent waiting, counters
    bit m_err;
    int m_wait;
    int m_stall, m_flush;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .IFID_Rs        (IFID_Rs),
        .IFID_Rt        (IFID_Rt),
        .IFID_UsesRt    (IFID_UsesRt),
        .IDEX_Rt        (IDEX_Rt),
        .IDEX_MemRead   (IDEX_MemRead),
        .EXMEM_MemRead  (EXMEM_MemRead),
        .EXMEM_MemWrite (EXMEM_MemWrite),
        .dmem_ready     (dmem_ready),
        .ID_BranchTaken (ID_BranchTaken),
        .PCWrite        (PCWrite),
        .IFID_Write     (IFID_Write),
        .IDEX_Bubble    (IDEX_Bubble),
        .IFID_Flush     (IFID_Flush),
        .Pipe_Freeze    (Pipe_Freeze),
        .mem_err        (mem_err),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        IFID_Rs = 5'd0; IFID_Rt = 5'd0; IFID_UsesRt = 1'b0;
        IDEX_Rt = 5'd0; IDEX_MemRead = 1'b0;
        EXMEM_MemRead = 1'b0; EXMEM_MemWrite = 1'b0;
        dmem_ready = 1'b1; ID_BranchTaken = 1'b0;
    endtask

    // called just after a falling edge with inputs settled; checks, then clocks
    task automatic step();
        bit ms, lu, e_pc, e_bub, e_fl, e_frz;
        #1;
        ms = (EXMEM_MemRead || EXMEM_MemWrite) && !dmem_ready;
        lu = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
             ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
        e_pc = 1'b1; e_bub = 1'b0; e_fl = 1'b0; e_frz = 1'b0;
        if (m_err || ms) begin
            e_pc = 1'b0; e_frz = 1'b1;
        end else if (lu) begin
            e_pc = 1'b0; e_bub = 1'b1;
        end else if (ID_BranchTaken) begin
            e_fl = 1'b1;
        end
        check_eq("PCWrite", 32'(PCWrite), 32'(e_pc));
        check_eq("IFID_Write", 32'(IFID_Write), 32'(e_pc));
        check_eq("IDEX_Bubble", 32'(IDEX_Bubble), 32'(e_bub));
        check_eq("IFID_Flush", 32'(IFID_Flush), 32'(e_fl));
        check_eq("Pipe_Freeze", 32'(Pipe_Freeze), 32'(e_frz));
        check_eq("mem_err", 32'(mem_err), 32'(m_err));
        check_eq("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check_eq("flush_count", 32'(flush_count), 32'(m_flush));
        @(posedge clk);
        if (!e_pc && !m_err && m_stall < CMAX) m_stall++;
        if (e_fl && m_flush < CMAX) m_flush++;
        if (!m_err) begin
            if (m_wait == 0) m_wait = ms ? 1 : 0;
            else if (dmem_ready) m_wait = 0;
            else if (m_wait == TO - 1) m_err = 1'b1;
            else m_wait++;
        end
        @(negedge clk);
    endtask

    // reset with hostile inputs applied; outputs must still show the defaults
    task automatic do_reset();
        rst = 1'b1;
        EXMEM_MemRead = 1'b1; dmem_ready = 1'b0;
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd3; IFID_Rs = 5'd3; ID_BranchTaken = 1'b1;
        #1;
        check_eq("rst_PCWrite", 32'(PCWrite), 32'd1);
        check_eq("rst_IFID_Write", 32'(IFID_Write), 32'd1);
        check_eq("rst_Freeze", 32'(Pipe_Freeze), 32'd0);
        check_eq("rst_Bubble", 32'(IDEX_Bubble), 32'd0);
        check_eq("rst_Flush", 32'(IFID_Flush), 32'd0);
        check_eq("rst_mem_err", 32'(mem_err), 32'd0);
        check_eq("rst_stall", 32'(stall_cycles), 32'd0);
        check_eq("rst_flush", 32'(flush_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_err = 1'b0; m_wait = 0; m_stall = 0; m_flush = 0;
        idle();
    endtask

    initial begin
        idle();
        m_err = 1'b0; m_wait = 0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        do_reset();

        // load-use on Rs: one stall cycle, then the load has moved on
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
        step();
        idle(); step();
        check_eq("t1_stall_cnt", 32'(stall_cycles), 32'd1);
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0;
        step();
        check_eq("t1_r0_nostall", 32'(stall_cycles), 32'd1);

        // Rt match only counts when the instruction reads Rt
        idle(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd9; IFID_Rt = 5'd9; IFID_Rs = 5'd2;
        step();
        IFID_UsesRt = 1'b1; step();
        idle(); step();
        check_eq("t2_stall_cnt", 32'(stall_cycles), 32'd2);

        // three-cycle memory wait then ready
        do_reset();
        EXMEM_MemRead = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        dmem_ready = 1'b1; step();
        idle(); step();
        check_eq("t3_stall_cnt", 32'(stall_cycles), 32'd3);
        check_eq("t3_back_run", 32'(PCWrite), 32'd1);

        // branch with load-use: stall first, flush next cycle
        do_reset();
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd4; IFID_Rs = 5'd4; ID_BranchTaken = 1'b1;
        step();
        IDEX_MemRead = 1'b0; step();
        idle(); step();
        check_eq("t4_flush_cnt", 32'(flush_count), 32'd1);
        check_eq("t4_stall_cnt", 32'(stall_cycles), 32'd1);

        // timeout into ERR, then reset out of it
        do_reset();
        EXMEM_MemRead = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < TO; i++) step();
        idle();
        check_eq("t5_mem_err", 32'(mem_err), 32'd1);
        check_eq("t5_freeze_held", 32'(Pipe_Freeze), 32'd1);
        step(); step();
        check_eq("t5_stall_cnt", 32'(stall_cycles), 32'(TO));
        do_reset();
        step();

        // counter saturation
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
        for (int i = 0; i < 17; i++) step();
        check_eq("t6_saturate", 32'(stall_cycles), 32'(CMAX));

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            IFID_Rs        = 5'($urandom_range(0, 3));
            IFID_Rt        = 5'($urandom_range(0, 3));
            IDEX_Rt        = 5'($urandom_range(0, 3));
            IFID_UsesRt    = 1'($urandom_range(0, 1));
            IDEX_MemRead   = 1'($urandom_range(0, 1));
            EXMEM_MemRead  = ($urandom_range(0, 3) == 0);
            EXMEM_MemWrite = ($urandom_range(0, 5) == 0);
            dmem_ready     = ($urandom_range(0, 9) > 3);
            ID_BranchTaken = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
